// File: rtl/md_pkg.sv
// Shared op-codes, FSM states and helpers for the HI/LO multiply/divide unit.
// The magnitude helper works on a 64-bit view, so the unit supports WIDTH up to 64.
package md_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_MULT  = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_DIV   = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADDU = 4'd7;
    localparam logic [3:0] OP_MADD  = 4'd8;
    localparam logic [3:0] OP_MSUBU = 4'd9;
    localparam logic [3:0] OP_MSUB  = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX
    } md_state_t;

    typedef enum logic [1:0] {
        ACC_SET,
        ACC_ADD,
        ACC_SUB
    } md_acc_t;

    localparam int MD_MAG_W = 64;

    // Absolute value of a sign-extended operand; unsigned ops pass straight through.
    function automatic logic [MD_MAG_W-1:0] md_mag(input logic signed [MD_MAG_W-1:0] v,
                                                   input logic                       is_signed);
        return (is_signed && v[MD_MAG_W-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/md_divider.sv
// Bit-serial restoring divider: one quotient bit per cycle on operand magnitudes,
// with sign correction and divide-by-zero results applied on the outputs.
module md_divider
    import md_pkg::*;
#(
    parameter int WIDTH = 32
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             signed_op,
    input  logic             cancel,
    output logic             busy,
    output logic             last,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int IT_W = $clog2(WIDTH + 1);

    logic [IT_W-1:0]         iter;
    logic [WIDTH-1:0]        rem_p0;
    logic [WIDTH-1:0]        quo_p0;
    logic [WIDTH-1:0]        dvs_p0;
    logic [WIDTH-1:0]        dvd_raw;
    logic                    neg_q;
    logic                    neg_r;
    logic                    div_zero;
    logic signed [WIDTH-1:0] dvd_s;
    logic signed [WIDTH-1:0] dvs_s;
    logic [WIDTH-1:0]        dvd_mag;
    logic [WIDTH-1:0]        dvs_mag;
    logic [WIDTH:0]          rem_sh;
    logic [WIDTH:0]          trial;

    assign dvd_s   = dividend;
    assign dvs_s   = divisor;
    assign dvd_mag = WIDTH'(md_mag(MD_MAG_W'(dvd_s), signed_op));
    assign dvs_mag = WIDTH'(md_mag(MD_MAG_W'(dvs_s), signed_op));

    assign rem_sh = {rem_p0, quo_p0[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, dvs_p0};
    assign busy   = (iter != '0);
    assign last   = (iter == IT_W'(1));

    always_ff @(posedge clk) begin
        if (reset || cancel) begin
            iter <= '0;
        end else if (start) begin
            iter <= IT_W'(WIDTH);
        end else if (busy) begin
            iter <= iter - IT_W'(1);
        end
    end

    // Stage p0: the dividend shifts out of quo_p0 while quotient bits shift in.
    always_ff @(posedge clk) begin
        if (start) begin
            rem_p0   <= '0;
            quo_p0   <= dvd_mag;
            dvs_p0   <= dvs_mag;
            dvd_raw  <= dividend;
            neg_q    <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r    <= signed_op & dividend[WIDTH-1];
            div_zero <= (divisor == '0);
        end else if (busy) begin
            if (!trial[WIDTH]) begin
                rem_p0 <= trial[WIDTH-1:0];
                quo_p0 <= {quo_p0[WIDTH-2:0], 1'b1};
            end else begin
                rem_p0 <= rem_sh[WIDTH-1:0];
                quo_p0 <= {quo_p0[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        quotient  = quo_p0;
        remainder = rem_p0;
        if (div_zero) begin
            quotient  = '1;
            remainder = dvd_raw;
        end else begin
            if (neg_q) quotient  = -quo_p0;
            if (neg_r) remainder = -rem_p0;
        end
    end

endmodule

// File: rtl/hilo_md_unit.sv
// HI/LO multiply/divide unit: fixed-latency multiplier, bit-serial divider, MTHI/MTLO.
// Define HILO_MD_MADD_EN to add the MADDU/MADD/MSUBU/MSUB accumulate ops (7-10).
module hilo_md_unit
    import md_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(MUL_LAT + 1);

    md_state_t               state;
    md_state_t               next_state;
    logic [CNT_W-1:0]        cnt;
    logic                    is_mul;
    logic                    mul_signed;
    logic                    is_div;
    logic                    div_signed;
    logic                    accept;
    logic                    ld_mul;
    logic                    div_start;
    logic                    wr_mthi;
    logic                    wr_mtlo;
    logic                    wr_mul;
    logic                    wr_div;
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic signed [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0]      prod_u;
    logic [2*WIDTH-1:0]      prod_d;
    logic [2*WIDTH-1:0]      prod_p0;
    logic [2*WIDTH-1:0]      mul_result;
    logic                    div_busy;
    logic                    div_last;
    logic [WIDTH-1:0]        div_quo;
    logic [WIDTH-1:0]        div_rem;
`ifdef HILO_MD_MADD_EN
    md_acc_t                 acc_sel;
    md_acc_t                 acc_p0;
`endif

    always_comb begin
        is_mul     = 1'b0;
        mul_signed = 1'b0;
        is_div     = 1'b0;
        div_signed = 1'b0;
`ifdef HILO_MD_MADD_EN
        acc_sel    = ACC_SET;
`endif
        case (op)
            OP_MULTU: is_mul = 1'b1;
            OP_MULT:  begin is_mul = 1'b1; mul_signed = 1'b1; end
            OP_DIVU:  is_div = 1'b1;
            OP_DIV:   begin is_div = 1'b1; div_signed = 1'b1; end
`ifdef HILO_MD_MADD_EN
            OP_MADDU: begin is_mul = 1'b1; acc_sel = ACC_ADD; end
            OP_MADD:  begin is_mul = 1'b1; mul_signed = 1'b1; acc_sel = ACC_ADD; end
            OP_MSUBU: begin is_mul = 1'b1; acc_sel = ACC_SUB; end
            OP_MSUB:  begin is_mul = 1'b1; mul_signed = 1'b1; acc_sel = ACC_SUB; end
`endif
            default: ;
        endcase
    end

    assign a_s    = a;
    assign b_s    = b;
    assign prod_s = (2*WIDTH)'(a_s) * (2*WIDTH)'(b_s);
    assign prod_u = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    assign prod_d = mul_signed ? prod_s : prod_u;

    // Stage p0: product captured at the accepting edge; the latency is pure wait.
    always_ff @(posedge clk) begin
        if (ld_mul) begin
            prod_p0 <= prod_d;
`ifdef HILO_MD_MADD_EN
            acc_p0  <= acc_sel;
`endif
        end
    end

`ifdef HILO_MD_MADD_EN
    always_comb begin
        case (acc_p0)
            ACC_ADD: mul_result = {hi, lo} + prod_p0;
            ACC_SUB: mul_result = {hi, lo} - prod_p0;
            default: mul_result = prod_p0;
        endcase
    end
`else
    assign mul_result = prod_p0;
`endif

    md_divider #(
        .WIDTH(WIDTH)
    ) u_divider (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (a),
        .divisor   (b),
        .signed_op (div_signed),
        .cancel    (cancel),
        .busy      (div_busy),
        .last      (div_last),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept && is_mul)      next_state = ST_MUL;
                else if (accept && is_div) next_state = ST_DIV;
            end
            ST_MUL:  if (cancel || cnt == CNT_W'(1)) next_state = ST_IDLE;
            ST_DIV: begin
                if (cancel || !div_busy) next_state = ST_IDLE;
                else if (div_last)       next_state = ST_FIX;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // A cancel in the same cycle as a start drops the op, including MTHI/MTLO.
    always_comb begin
        accept    = start && (state == ST_IDLE) && !cancel;
        ld_mul    = accept && is_mul;
        div_start = accept && is_div;
        wr_mthi   = accept && (op == OP_MTHI);
        wr_mtlo   = accept && (op == OP_MTLO);
        wr_mul    = (state == ST_MUL) && !cancel && (cnt == CNT_W'(1));
        wr_div    = (state == ST_FIX) && !cancel;
        busy      = (state != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
            cnt  <= '0;
        end else begin
            done <= wr_mul || wr_div;
            if (wr_mthi) hi <= a;
            if (wr_mtlo) lo <= a;
            if (wr_mul) {hi, lo} <= mul_result;
            if (wr_div) begin
                hi <= div_rem;
                lo <= div_quo;
            end
            if (ld_mul)                cnt <= CNT_W'(MUL_LAT);
            else if (state == ST_MUL)  cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hilo_md_unit.sv
// Self-checking bench for hilo_md_unit: directed corner cases plus random ops
// compared against an arithmetic reference model of HI/LO.
module tb_hilo_md_unit;

    localparam int W    = 32;
    localparam int LAT  = 5;
    localparam int DLAT = W + 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         cancel;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;

    hilo_md_unit #(.WIDTH(W), .MUL_LAT(LAT)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural effect of one op on HI/LO and its busy latency (0 = immediate).
    function automatic void model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic [W-1:0] h, input logic [W-1:0] l,
                                  output logic [W-1:0] nh, output logic [W-1:0] nl, output int lat);
        longint          sx;
        longint          sy;
        longint unsigned ux;
        longint unsigned uy;
        logic [63:0]     acc;
        logic [63:0]     r;
        sx  = $signed(x);
        sy  = $signed(y);
        ux  = x;
        uy  = y;
        acc = {h, l};
        nh  = h;
        nl  = l;
        lat = 0;
        case (o)
            4'd1: begin r = ux * uy; {nh, nl} = r; lat = LAT; end
            4'd2: begin r = sx * sy; {nh, nl} = r; lat = LAT; end
            4'd3: begin
                lat = DLAT;
                if (y == 0) begin nl = '1; nh = x; end
                else begin nl = x / y; nh = x % y; end
            end
            4'd4: begin
                lat = DLAT;
                if (y == 0) begin nl = '1; nh = x; end
                else begin
                    r  = sx / sy;
                    nl = r[W-1:0];
                    r  = sx % sy;
                    nh = r[W-1:0];
                end
            end
            4'd5: nh = x;
            4'd6: nl = x;
`ifdef HILO_MD_MADD_EN
            4'd7:  begin r = ux * uy; {nh, nl} = acc + r; lat = LAT; end
            4'd8:  begin r = sx * sy; {nh, nl} = acc + r; lat = LAT; end
            4'd9:  begin r = ux * uy; {nh, nl} = acc - r; lat = LAT; end
            4'd10: begin r = sx * sy; {nh, nl} = acc - r; lat = LAT; end
`endif
            default: ;
        endcase
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'd1;
            2:       return '1;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] eh;
        logic [W-1:0] el;
        int           lat;
        int           k;
        bit           busy_ok;
        model(o, x, y, m_hi, m_lo, eh, el, lat);
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        check("done_clear", done, 0);
        if (lat == 0) begin
            check("busy_imm", busy, 0);
        end else begin
            check("busy_t0", busy, 1);
            k = 0;
            busy_ok = 1'b1;
            while (!done && k < lat + 4) begin
                if (!busy) busy_ok = 1'b0;
                a = $urandom;
                b = $urandom;
                tick();
                k++;
            end
            check("latency", k, lat);
            check("busy_held", busy_ok, 1);
            check("busy_end", busy, 0);
        end
        check("hi", hi, eh);
        check("lo", lo, el);
        m_hi = eh;
        m_lo = el;
    endtask

    initial begin
        int k;
        bit saw;
        reset = 1'b1; start = 1'b0; cancel = 1'b0; op = 4'd0; a = '0; b = '0;
        tick();
        tick();
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;

        run_op(4'd2, 32'hFFFF_FFFE, 32'd3);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);
        run_op(4'd4, 32'hFFFF_FFF9, 32'd2);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        run_op(4'd3, 32'd7, 32'd0);
        check("divz_lo", lo, 32'hFFFF_FFFF);
        check("divz_hi", hi, 32'd7);
        run_op(4'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        check("divmin_lo", lo, 32'h8000_0000);
        check("divmin_hi", hi, 32'd0);
        run_op(4'd5, 32'h1234_5678, 32'd0);
        run_op(4'd6, 32'h9ABC_DEF0, 32'd0);
        check("mthi", hi, 32'h1234_5678);
        check("mtlo", lo, 32'h9ABC_DEF0);

        op = 4'd5; a = 32'hDEAD_BEEF; start = 1'b1; cancel = 1'b1;
        tick();
        start = 1'b0; cancel = 1'b0;
        check("cancel_start_hi", hi, m_hi);
        check("cancel_start_busy", busy, 0);

        op = 4'd3; a = 32'd100; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        saw = 1'b0;
        repeat (9) begin tick(); if (done) saw = 1'b1; end
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel_busy", busy, 0);
        check("cancel_hi", hi, m_hi);
        check("cancel_lo", lo, m_lo);
        repeat (DLAT) begin tick(); if (done || busy) saw = 1'b1; end
        check("cancel_quiet", saw, 0);

        run_op(4'd5, 32'd0, 32'd0);
        run_op(4'd6, 32'hFFFF_FFFF, 32'd0);
        run_op(4'd7, 32'd1, 32'd1);
`ifdef HILO_MD_MADD_EN
        check("maddu_hi", hi, 32'd1);
        check("maddu_lo", lo, 32'd0);
`else
        check("maddu_nop_hi", hi, 32'd0);
        check("maddu_nop_lo", lo, 32'hFFFF_FFFF);
`endif

        op = 4'd3; a = 32'd100; b = 32'd7; start = 1'b1;
        tick();
        k = 0;
        while (!done && k < DLAT + 4) begin
            if (k == 3) begin op = 4'd1; a = 32'd5; b = 32'd6; start = 1'b1; end
            else start = 1'b0;
            tick();
            k++;
        end
        start = 1'b0;
        check("busy_start_latency", k, DLAT);
        check("busy_start_lo", lo, 32'd14);
        check("busy_start_hi", hi, 32'd2);
        m_hi = 32'd2;
        m_lo = 32'd14;
        saw = 1'b0;
        repeat (LAT + 2) begin tick(); if (busy || done) saw = 1'b1; end
        check("no_queue", saw, 0);
        check("no_queue_hi", hi, 32'd2);

        op = 4'd4; a = $urandom; b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_hi", hi, 0);
        check("midrst_lo", lo, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        m_hi = '0;
        m_lo = '0;

        for (int i = 0; i < 60; i++) begin
            logic [3:0]   o;
            logic [W-1:0] x;
            logic [W-1:0] y;
            o = 4'($urandom_range(0, 15));
            x = pick();
            y = pick();
            if ($urandom_range(0, 7) == 0) y = '0;
            run_op(o, x, y);
        end

        tick();
        check("final_done", done, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hilo_md_unit.md
# hilo_md_unit

Parametrised HI/LO multiply/divide unit for the CPU execute stage. Successor to the fixed-latency 32-bit unit: width and multiply latency are parameters, division is a true bit-serial restoring divider, and an in-flight operation can be cancelled by the pipeline on an exception or flush. Multiply-accumulate ops are optional, selected at compile time. HI/LO are architectural registers read directly by the datapath.

## Interface
- WIDTH, 32, operand and HI/LO width (≥8)
- MUL_LAT, 5, cycles busy for multiply-class ops (≥1)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high; clock clk
- start  in  1  issue op this cycle (accepted only when busy=0)
- op  in  4  operation code (md_pkg encoding)
- a  in  WIDTH  operand 1 (rs / dividend / MTHI-MTLO source)
- b  in  WIDTH  operand 2 (rt / divisor)
- cancel  in  1  abort in-flight op; HI/LO keep old values
- busy  out  1  op in flight; start ignored while high
- done  out  1  one-cycle pulse on the edge HI/LO take a result
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- Ops: NOP=0, MULTU=1, MULT=2, DIVU=3, DIV=4, MTHI=5, MTLO=6, MADDU=7, MADD=8, MSUBU=9, MSUB=10; 11-15 act as NOP.
- States: IDLE, MUL, DIV, FIX. Reset -> IDLE; hi=0, lo=0, busy=0, done=0.
- IDLE, start, MTHI/MTLO: hi (or lo) <= a on the accepting edge; no busy, no done.
- IDLE, start, mult-class: operands latched, full 2·WIDTH product computed (signed for MULT/MADD/MSUB); counter=MUL_LAT -> MUL.
- MUL: counter decrements; at 1, {hi,lo} <= product (MULT/MULTU), {hi,lo}+product (MADD*), {hi,lo}−product (MSUB*), modulo 2^(2·WIDTH); busy<=0, done<=1 -> IDLE.
- IDLE, start, DIVU/DIV: magnitudes latched, sign flags saved, iter=WIDTH -> DIV.
- DIV: one restoring step per cycle (shift remainder, trial subtract, set quotient bit); after WIDTH steps -> FIX.
- FIX: quotient negated if operand signs differ (DIV); remainder takes dividend sign; lo<=quotient, hi<=remainder; done -> IDLE.
- Divide by zero: lo=all ones, hi=a; still full divide latency.
- DIV of MIN by −1: lo=MIN, hi=0.
- cancel while busy: -> IDLE next edge, busy<=0, done stays 0, HI/LO unchanged. cancel in IDLE: no effect; cancel wins over a same-cycle start (op dropped).
- start while busy: ignored, no queuing.
- reset mid-op: overrides everything, as above.

## Timing
- Accept edge T0 (start & !busy). busy high from T0+1.
- Mult-class: result and done visible after edge T0+MUL_LAT; busy low at same time. Busy for MUL_LAT cycles.
- Divide: WIDTH step cycles + 1 FIX cycle; result after edge T0+WIDTH+1.
- New start accepted in the cycle busy first reads 0.
- MTHI/MTLO: value visible after T0; back-to-back accepted every cycle.
- Outputs registered; no combinational input-to-output path.

## Configuration
- HILO_MD_MADD_EN defined: MADDU/MADD/MSUBU/MSUB implemented as above.
- Undefined: ops 7-10 decode as NOP (no busy, HI/LO unchanged); accumulate adder removed.

## Structure
- md_pkg: op-code localparams, state enum, helper function for signed magnitude.
- Sub-module md_divider: bit-serial restoring divider (start, dividend, divisor, signed flag, cancel -> busy, quotient, remainder); top instantiates it plus multiplier and HI/LO state machine.

## Test plan
- MULT a=0xFFFFFFFE (−2), b=3 -> after 5 cycles hi=0xFFFFFFFF, lo=0xFFFFFFFA, done 1 pulse.
- DIV a=0xFFFFFFF9 (−7), b=2 -> after 33 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> lo=0xFFFFFFFF, hi=7.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles -> hi/lo updated next edges, busy stays 0.
- DIVU 100/7 started, cancel on cycle 10 -> busy low next edge, hi/lo hold prior values, no done.
- MADDU with hi=0, lo=0xFFFFFFFF, a=1, b=1 -> hi=1, lo=0 (macro defined); macro undefined -> hi/lo unchanged, busy never set.
- start MULTU while busy from DIVU -> ignored; reset mid-divide -> hi=lo=0, busy=0 next edge.
